// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero register, write bypass and post-reset clearing.
// Latency: reads are combinational (0 cycles); writes land at the clock edge; clearing takes 2**ADDR_W edges.
// Backpressure: none; writes during clearing are discarded and reported by a one-cycle wr_drop pulse.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int LED_IDX  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       init_busy,
  output logic                       wr_drop,
  output logic [7:0]                 led_o
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(LED_IDX);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                wr_drop_nxt;

  // Single write port into the array, shared by the clearing sequencer and normal writes.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  // Storage has no reset so it can map onto distributed RAM; clearing is done by the sequencer.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Writes aimed at a hard-wired zero entry are silently ignored everywhere.
  logic                wr_to_zero;
  logic                bypass_act;

  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign bypass_act = (BYPASS != 0) && we;

  // Sequencer state, clear counter and drop flag; rst restarts clearing from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_drop <= wr_drop_nxt;
    end
  end

  // Next-state logic and array write steering: INIT zeroes mem[cnt], RUN takes user writes.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_drop_nxt = 1'b0;
    init_busy   = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = wr_addr;
    mem_wd      = wr_data;
    case (state)
      ST_INIT: begin
        init_busy   = 1'b1;
        mem_we      = !rst;
        mem_wa      = cnt[ADDR_W-1:0];
        mem_wd      = '0;
        cnt_nxt     = cnt + CNT_ONE;
        wr_drop_nxt = we && !wr_to_zero;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = !rst && we && !wr_to_zero;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Array write; the only process touching mem.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Per-port combinational read: zero register first, then bypass, then the array.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      if (state != ST_RUN) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end else if (bypass_act && (wr_addr == ra)) begin
        rd_data[p*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = mem[ra];
      end
    end
  end

  // LED tap: top byte of entry LED_IDX, following the same read priority as the ports.
  always_comb begin
    led_o = 8'h00;
    if (state != ST_RUN) begin
      led_o = 8'h00;
    end else if ((ZERO_REG != 0) && (LED_ADDR == '0)) begin
      led_o = 8'h00;
    end else if (bypass_act && (wr_addr == LED_ADDR)) begin
      led_o = wr_data[DATA_W-1 -: 8];
    end else begin
      led_o = mem[LED_ADDR][DATA_W-1 -: 8];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, a no-bypass build and a small 4-port build.
// Latency: checks sampled 1 time unit after the falling edge, inputs applied on the falling edge.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the bypass (_b) and no-bypass (_n) default-size instances.
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy_b, busy_n, drop_b, drop_n;
  logic [7:0]  led_b, led_n;

  // Small instance: 16-bit data, 8 entries, 4 read ports.
  logic        rst_s;
  logic [11:0] rd_addr_s;
  logic [63:0] rd_data_s;
  logic        we_s;
  logic [2:0]  wr_addr_s;
  logic [15:0] wr_data_s;
  logic        busy_s, drop_s;
  logic [7:0]  led_s;

  regfile_mp u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .init_busy(busy_b), .wr_drop(drop_b), .led_o(led_b)
  );

  regfile_mp #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .init_busy(busy_n), .wr_drop(drop_n), .led_o(led_n)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_small (
    .clk(clk), .rst(rst_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s), .we(we_s),
    .wr_addr(wr_addr_s), .wr_data(wr_data_s), .init_busy(busy_s), .wr_drop(drop_s), .led_o(led_s)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;   // bypass build, port 0
    logic [31:0] e1;   // bypass build, port 1
    logic [7:0]  el;   // bypass build, led
    logic [31:0] n0;   // no-bypass build, port 0
    logic [31:0] n1;   // no-bypass build, port 1
    logic [7:0]  nl;   // no-bypass build, led
  } vec_t;

  vec_t vt [12];

  initial begin
    int n;
    int bad;

    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd6, 5'd6, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 8'h00};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF, 8'h00};
    vt[2]  = '{1'b0, 5'd0, 32'h0,        5'd6, 5'd6, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 8'h00};
    vt[3]  = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 8'h00};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 8'h00};
    vt[5]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 32'hDEADBEEF, 32'hA5A5A5A5, 8'h00, 32'hDEADBEEF, 32'h0, 8'h00};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 8'h00, 32'hA5A5A5A5, 32'hA5A5A5A5, 8'h00};
    vt[7]  = '{1'b1, 5'd2, 32'hFF000000, 5'd2, 5'd5, 32'hFF000000, 32'hDEADBEEF, 8'hFF, 32'h0, 32'hDEADBEEF, 8'h00};
    vt[8]  = '{1'b0, 5'd0, 32'h0,        5'd2, 5'd2, 32'hFF000000, 32'hFF000000, 8'hFF, 32'hFF000000, 32'hFF000000, 8'hFF};
    vt[9]  = '{1'b1, 5'd2, 32'h12ABCDEF, 5'd2, 5'd7, 32'h12ABCDEF, 32'hA5A5A5A5, 8'h12, 32'hFF000000, 32'hA5A5A5A5, 8'hFF};
    vt[10] = '{1'b1, 5'd2, 32'hFF000000, 5'd2, 5'd2, 32'hFF000000, 32'hFF000000, 8'hFF, 32'h12ABCDEF, 32'h12ABCDEF, 8'h12};
    vt[11] = '{1'b0, 5'd0, 32'h0,        5'd2, 5'd0, 32'hFF000000, 32'h0, 8'hFF, 32'hFF000000, 32'h0, 8'hFF};

    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    rst_s = 1'b1; we_s = 1'b0; wr_addr_s = '0; wr_data_s = '0; rd_addr_s = '0;

    // Two reset edges, then reset values.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", busy_b, 1);
    chk("rst_drop", drop_b, 0);
    chk("rst_rd", rd_data_b, 0);
    chk("rst_led", led_b, 0);
    chk("rst_busy_small", busy_s, 1);

    // Clearing sequence with a dropped write in cycle 10 and a zero-register write in cycle 12.
    for (int i = 0; i < 34; i++) begin
      if (i > 0) @(negedge clk);
      rst     = 1'b0;
      we      = (i == 10) || (i == 12);
      wr_addr = (i == 10) ? 5'd3 : 5'd0;
      wr_data = (i == 10) ? 32'h000000FF : 32'h12345678;
      rd_addr = {5'd5, 5'd3};
      #1;
      chk($sformatf("init_busy_c%0d", i), busy_b, (i < 32) ? 64'd1 : 64'd0);
      chk($sformatf("init_busy_nb_c%0d", i), busy_n, (i < 32) ? 64'd1 : 64'd0);
      chk($sformatf("init_drop_c%0d", i), drop_b, (i == 11) ? 64'd1 : 64'd0);
      chk($sformatf("init_drop_nb_c%0d", i), drop_n, (i == 11) ? 64'd1 : 64'd0);
      chk($sformatf("init_rd_c%0d", i), rd_data_b, 0);
      chk($sformatf("init_led_c%0d", i), led_b, 0);
    end

    // Every non-zero entry reads back cleared, including r3 which saw a dropped write.
    @(negedge clk);
    we = 1'b0;
    for (int k = 1; k < 32; k++) begin
      rd_addr = {5'(k), 5'(k)};
      #1;
      chk($sformatf("clear_r%0d", k), rd_data_b, 0);
      chk($sformatf("clear_nb_r%0d", k), rd_data_n, 0);
    end

    // Table-driven run-mode vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we      = vt[i].we;
      wr_addr = vt[i].wa;
      wr_data = vt[i].wd;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      #1;
      chk($sformatf("v%0d_p0", i), rd_data_b[31:0], vt[i].e0);
      chk($sformatf("v%0d_p1", i), rd_data_b[63:32], vt[i].e1);
      chk($sformatf("v%0d_led", i), led_b, vt[i].el);
      chk($sformatf("v%0d_nb_p0", i), rd_data_n[31:0], vt[i].n0);
      chk($sformatf("v%0d_nb_p1", i), rd_data_n[63:32], vt[i].n1);
      chk($sformatf("v%0d_nb_led", i), led_n, vt[i].nl);
      chk($sformatf("v%0d_drop", i), drop_b, 0);
      chk($sformatf("v%0d_busy", i), busy_b, 0);
    end

    // Reset mid-run with a write on the reset edge: no drop pulse, contents lost.
    @(negedge clk);
    rst = 1'b1; we = 1'b1; wr_addr = 5'd9; wr_data = 32'h55555555;
    @(negedge clk);
    rst = 1'b0; we = 1'b0; rd_addr = {5'd2, 5'd9};
    #1;
    chk("rerun_busy", busy_b, 1);
    chk("rerun_drop", drop_b, 0);
    chk("rerun_led", led_b, 0);
    n = 0;
    bad = 0;
    while (busy_b && n < 100) begin
      if (led_b != 8'h00 || rd_data_b != 64'h0 || drop_b != 1'b0) bad++;
      n++;
      @(negedge clk);
      #1;
    end
    chk("rerun_init_cycles", 64'(n), 32);
    chk("rerun_init_outputs", 64'(bad), 0);
    chk("rerun_r9", rd_data_b[31:0], 0);
    chk("rerun_r2", rd_data_b[63:32], 0);
    chk("rerun_r2_nb", rd_data_n[63:32], 0);
    chk("rerun_led_after", led_b, 0);

    // Small build: 8-entry clear, 4 ports, 16-bit LED tap.
    @(negedge clk);
    rst_s = 1'b0;
    #1;
    n = 0;
    while (busy_s && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("small_init_cycles", 64'(n), 8);
    @(negedge clk);
    we_s = 1'b1; wr_addr_s = 3'd2; wr_data_s = 16'hFF00;
    rd_addr_s = {3'd2, 3'd2, 3'd2, 3'd2};
    #1;
    chk("small_bypass_rd", rd_data_s, {4{16'hFF00}});
    chk("small_bypass_led", led_s, 8'hFF);
    @(negedge clk);
    we_s = 1'b0;
    #1;
    chk("small_rd", rd_data_s, {4{16'hFF00}});
    chk("small_led", led_s, 8'hFF);
    @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    #1;
    chk("small_rerun_busy", busy_s, 1);
    chk("small_rerun_led", led_s, 0);
    n = 0;
    while (busy_s && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("small_rerun_cycles", 64'(n), 8);
    chk("small_rerun_rd", rd_data_s, 0);
    chk("small_rerun_led_after", led_s, 0);
    chk("small_drop", drop_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
